fetch_queue: RTL and testbench
==============================

# fetch_queue

Parametrised instruction-fetch front end that replaces the combinational PC register/increment/mux path of the single-cycle datapath. It owns the fetch PC, issues requests to a variable-latency instruction memory, buffers returned words in a DEPTH-entry queue, and presents {instruction, PC, PC+4} to decode through a valid/ready handshake. It supports redirects (branch/jump), with flush and stale-response discard, and a halt input for EBREAK-style freeze.

## Interface
- XLEN, 32: PC/address width (≥ 8).
- DEPTH, 4: queue entries and maximum in-flight plus buffered words (power of two, ≥ 2).
- RESET_PC, 0: fetch address after reset (word aligned).
- Clock/reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- imem_req  out  1  request valid.
- imem_addr  out  XLEN  byte address of the request; bits [1:0] always 0.
- imem_ready  in  1  memory accepts the request this cycle; a request is accepted when imem_req & imem_ready.
- imem_rvalid  in  1  response word valid; responses return in order, at least 1 cycle after acceptance.
- imem_rdata  in  32  response instruction.
- redirect  in  1  discard everything and refetch from redirect_pc.
- redirect_pc  in  XLEN  new fetch address; bits [1:0] ignored (treated as 0).
- halt  in  1  no new requests while high.
- out_valid  out  1  head entry valid.
- out_inst  out  32  head instruction.
- out_pc  out  XLEN  address of head instruction.
- out_pc_inc  out  XLEN  out_pc + 4, modulo 2^XLEN.
- out_ready  in  1  consumer takes the head when out_valid & out_ready.

## Operation
- State: fetch_pc; queue (count 0..DEPTH); outstanding counter (accepted requests not yet returned); stale counter (responses still to be dropped). All counters are $clog2(DEPTH+1) bits wide.
- Issue rule: imem_req = !rst & !halt & !redirect & (count + outstanding < DEPTH). The queue can never overflow.
- On an accepted request, fetch_pc advances by 4 and wraps modulo 2^XLEN. Each queue entry stores the address of its request.
- Response handling:
  - If stale > 0, a response decrements stale and is dropped.
  - Otherwise it is written at the queue tail and decrements outstanding.
- Pop: when out_valid & out_ready, the head is removed. Push and pop in the same cycle leave count unchanged; this is legal at count = DEPTH and at count = 0 only when a pop is impossible.
- Redirect cycle:
  - The queue is flushed (count ← 0).
  - stale ← stale + outstanding, minus 1 if a stale response arrives that cycle.
  - outstanding ← 0.
  - fetch_pc ← {redirect_pc[XLEN-1:2], 2'b00}.
  - A pop in the same cycle is discarded. Responses arriving in this cycle are dropped.
- Halt freezes fetch_pc and issue only. Responses still land in the queue, and the consumer may still drain it.
- If redirect and halt are both high, the redirect is applied and issue stays blocked until halt falls.

## Timing
- Reset values: imem_req 0, imem_addr RESET_PC, out_valid 0, out_inst 0, out_pc 0, out_pc_inc 4. All counters are 0 and fetch_pc = RESET_PC.
- First request is issued in the first cycle with rst low.
- out_* are driven from registers, with no combinational path from imem_rdata.
- Minimum latency is accept at t, rvalid at t+1, out_valid at t+2.
- Sustained throughput is one instruction per cycle when memory latency ≤ DEPTH−1 and out_ready is held high.
- Redirect at t: out_valid is 0 at t+1, the first request to the new PC is issued at t+1, and the earliest new instruction appears at t+3.
- Reset asserted mid-operation clears everything at the next edge. Responses for requests from before reset are not tracked; the memory is reset together with this block.

## Structure
- Shared defines file: FETCH_RESET_PC default and a NOP encoding constant 32'h00000013, which decode uses when out_valid = 0.
- One sub-module, inst_queue: a parametrised synchronous FIFO, WIDTH = 32 + XLEN, DEPTH entries, with push/pop/flush and count output. The wrap-around pointers live there.
- Issue, discard and PC logic stay in fetch_queue.

## Test plan
- Reset, 1-cycle memory, out_ready = 1: requests to 0x0, 0x4, 0x8 are issued back to back. From cycle 2 on, out_pc shows 0, 4, 8 with out_pc_inc 4, 8, 0xC, one per cycle.
- out_ready = 0 with DEPTH = 4: exactly 4 requests are accepted, then imem_req stays 0. After out_ready rises, a 5th request is issued the cycle after the first pop.
- Memory latency 3 with 3 requests in flight, redirect to 0x100: the 3 old responses are dropped. The next out_pc is 0x100, and 0x104 follows it.
- redirect_pc = 0x203: the fetch address and out_pc are 0x200.
- fetch_pc = 2^XLEN − 4: the next request address wraps to 0, and out_pc_inc for the head at 2^XLEN − 4 reads 0.
- halt raised with 2 in flight: both instructions are delivered, no further requests are made, and fetch_pc is held. After halt falls, fetch resumes at the held address.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue shared definitions.
// Reset fetch address, instruction width and the decode bubble word.
package fetch_queue_pkg;

    localparam int ILEN = 32;

    localparam logic [31:0] FETCH_RESET_PC = 32'h0000_0000;

    // addi x0, x0, 0: what decode issues while out_valid is low
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    typedef logic [ILEN-1:0] inst_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction memory request/response bus.
// master = fetch side, slave = memory side.
interface fetch_queue_if #(
    parameter int XLEN = 32
);
    import fetch_queue_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic            imem_rvalid;
    inst_t           imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue_inst_queue.sv
// inst_queue: synchronous FIFO with push/pop/flush.
// Pointers wrap naturally since DEPTH is a power of two.
module inst_queue #(
    parameter  int WIDTH = 64,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && !flush && (count != '0);
    assign do_push = push && !flush &&
                     ((count != CW'(DEPTH)) || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage write; contents need no reset since count gates them.
    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: fetch PC, request issue, stale discard and
// a buffered {inst, pc, pc+4} handshake towards decode.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(FETCH_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst,
    fetch_queue_if.master   imem,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    input  logic            halt,
    output logic            out_valid,
    output inst_t           out_inst,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_pc_inc,
    input  logic            out_ready
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int QW = ILEN + XLEN;

    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target_pc;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   stale;
    logic [CW-1:0]   count;
    logic [CW-1:0]   pending;
    logic [CW:0]     in_use;
    logic            accept;
    logic            resp;
    logic            resp_live;
    logic            pop;
    logic [QW-1:0]   head;

    // Queue slots are reserved at issue time, so a push always fits.
    assign in_use    = (CW+1)'(count) + (CW+1)'(outstanding);
    assign target_pc = redirect_pc & ~XLEN'(3);
    assign pending   = stale + outstanding;

    assign imem.imem_req  = !rst && !halt && !redirect &&
                            (in_use < (CW+1)'(DEPTH));
    assign imem.imem_addr = fetch_pc;

    assign accept    = imem.imem_req && imem.imem_ready;
    assign resp      = imem.imem_rvalid;
    assign resp_live = resp && (stale == '0) && !redirect;
    assign pop       = out_valid && out_ready && !redirect;

    // Issue PC and the PC tagged onto the next live response.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
            resp_pc  <= RESET_PC;
        end else if (redirect) begin
            fetch_pc <= target_pc;
            resp_pc  <= target_pc;
        end else begin
            if (accept)
                fetch_pc <= fetch_pc + XLEN'(4);
            if (resp_live)
                resp_pc <= resp_pc + XLEN'(4);
        end
    end

    // In-flight accounting: live requests vs. responses to drop.
    always_ff @(posedge clk) begin
        if (rst) begin
            outstanding <= '0;
            stale       <= '0;
        end else if (redirect) begin
            outstanding <= '0;
            stale       <= (resp && pending != '0) ?
                           pending - CW'(1) : pending;
        end else begin
            outstanding <= outstanding + CW'(accept)
                         - CW'(resp_live);
            if (resp && stale != '0)
                stale <= stale - CW'(1);
        end
    end

    inst_queue #(
        .WIDTH (QW),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .push  (resp_live),
        .pop   (pop),
        .flush (redirect),
        .wdata ({imem.imem_rdata, resp_pc}),
        .rdata (head),
        .count (count)
    );

    assign out_valid  = (count != '0);
    assign out_inst   = out_valid ? head[XLEN +: ILEN] : '0;
    assign out_pc     = out_valid ? head[XLEN-1:0] : '0;
    assign out_pc_inc = out_pc + XLEN'(4);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with an in-order
// fixed-latency instruction memory model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        halt = 1'b0;
    logic        out_ready = 1'b1;
    logic        out_valid;
    inst_t       out_inst;
    logic [31:0] out_pc;
    logic [31:0] out_pc_inc;

    int n_chk = 0;
    int n_pass = 0;
    int lat = 1;
    int cyc = 0;
    int acc_cnt = 0;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t mq[$];

    fetch_queue_if #(.XLEN(32)) bus ();

    fetch_queue #(
        .XLEN     (32),
        .DEPTH    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem        (bus),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halt        (halt),
        .out_valid   (out_valid),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .out_pc_inc  (out_pc_inc),
        .out_ready   (out_ready)
    );

    always #5 clk = ~clk;

    assign bus.imem_ready = 1'b1;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hC0DE_0013;
    endfunction

    // Memory: accept at the edge, answer lat cycles later in order.
    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            acc_cnt = 0;
        end else if (bus.imem_req && bus.imem_ready) begin
            mq.push_back('{addr: bus.imem_addr, due: cyc + lat});
            acc_cnt++;
        end
        cyc++;
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = inst_of(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rvalid = 1'b0;
            bus.imem_rdata  = '0;
        end
    end

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect = 1'b0;
        halt = 1'b0;
        step(2);
        rst = 1'b0;
        #1;
    endtask

    initial begin
        // reset state
        step(2); #1;
        check("rst_req", bus.imem_req, 0);
        check("rst_addr", bus.imem_addr, 0);
        check("rst_valid", out_valid, 0);
        check("rst_inst", out_inst, 0);
        check("rst_pc", out_pc, 0);
        check("rst_pc_inc", out_pc_inc, 4);

        // 1-cycle memory, back-to-back stream
        rst = 1'b0; #1;
        check("t1_req0", bus.imem_req, 1);
        check("t1_addr0", bus.imem_addr, 0);
        step(1); #1;
        check("t1_addr1", bus.imem_addr, 4);
        check("t1_v1", out_valid, 0);
        step(1); #1;
        check("t1_addr2", bus.imem_addr, 8);
        check("t1_v2", out_valid, 1);
        check("t1_pc2", out_pc, 0);
        check("t1_inc2", out_pc_inc, 4);
        check("t1_inst2", out_inst, inst_of(32'h0));
        step(1); #1;
        check("t1_pc3", out_pc, 4);
        check("t1_inc3", out_pc_inc, 8);
        step(1); #1;
        check("t1_pc4", out_pc, 8);
        check("t1_inc4", out_pc_inc, 32'hC);
        check("t1_inst4", out_inst, inst_of(32'h8));

        // backpressure fills the queue
        out_ready = 1'b0;
        lat = 1;
        do_reset();
        step(7); #1;
        check("t2_acc", acc_cnt, 4);
        check("t2_req_full", bus.imem_req, 0);
        check("t2_valid", out_valid, 1);
        check("t2_pc", out_pc, 0);
        out_ready = 1'b1; #1;
        check("t2_req_pop", bus.imem_req, 0);
        step(1); #1;
        check("t2_req5", bus.imem_req, 1);
        check("t2_addr5", bus.imem_addr, 32'h10);
        check("t2_pc_next", out_pc, 4);

        // redirect with 3 in flight, latency 3
        lat = 3;
        do_reset();
        step(3);
        redirect = 1'b1;
        redirect_pc = 32'h100;
        #1;
        check("t3_inflight", acc_cnt, 3);
        check("t3_req_rd", bus.imem_req, 0);
        step(1);
        redirect = 1'b0;
        #1;
        check("t3_valid_t1", out_valid, 0);
        check("t3_req_t1", bus.imem_req, 1);
        check("t3_addr_t1", bus.imem_addr, 32'h100);
        step(3); #1;
        check("t3_no_stale", out_valid, 0);
        step(1); #1;
        check("t3_valid", out_valid, 1);
        check("t3_pc0", out_pc, 32'h100);
        check("t3_inst0", out_inst, inst_of(32'h100));
        step(1); #1;
        check("t3_pc1", out_pc, 32'h104);

        // unaligned redirect target
        lat = 1;
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'h203;
        #1;
        check("t4_req_rd", bus.imem_req, 0);
        step(1);
        redirect = 1'b0;
        #1;
        check("t4_addr", bus.imem_addr, 32'h200);
        step(2); #1;
        check("t4_valid", out_valid, 1);
        check("t4_pc", out_pc, 32'h200);
        check("t4_inc", out_pc_inc, 32'h204);

        // PC wrap at the top of the address space
        do_reset();
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect = 1'b0;
        #1;
        check("t5_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
        step(1); #1;
        check("t5_addr_wrap", bus.imem_addr, 0);
        step(1); #1;
        check("t5_pc_top", out_pc, 32'hFFFF_FFFC);
        check("t5_inc_wrap", out_pc_inc, 0);
        step(1); #1;
        check("t5_pc_zero", out_pc, 0);
        check("t5_inc4", out_pc_inc, 4);

        // halt with 2 in flight
        lat = 3;
        do_reset();
        step(2);
        halt = 1'b1;
        #1;
        check("t6_req_halt", bus.imem_req, 0);
        check("t6_addr_hold", bus.imem_addr, 8);
        step(2); #1;
        check("t6_v0", out_valid, 1);
        check("t6_pc0", out_pc, 0);
        step(1); #1;
        check("t6_pc1", out_pc, 4);
        step(1); #1;
        check("t6_drained", out_valid, 0);
        step(2); #1;
        check("t6_req_still", bus.imem_req, 0);
        check("t6_acc", acc_cnt, 2);
        check("t6_addr_still", bus.imem_addr, 8);
        halt = 1'b0;
        #1;
        check("t6_req_resume", bus.imem_req, 1);
        check("t6_addr_resume", bus.imem_addr, 8);
        step(4); #1;
        check("t6_v_resume", out_valid, 1);
        check("t6_pc_resume", out_pc, 8);
        check("t6_inst_resume", out_inst, inst_of(32'h8));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
